// File: rtl/rgbw_scaler.sv
// rgbw_scaler: runs the four R/G/B/W x intensity products through the shared
// 8x8 multiplier, rounds each to 8 bits and publishes all four together.
module rgbw_scaler #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  intensity,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    input  logic [7:0]  w_in,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic [7:0]  w_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mul_ld,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_rdy,
    input  logic [15:0] mul_result
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYPASS,
        S_REQ,
        S_REL
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0][7:0] r_snap;
    logic [3:0][7:0] r_shadow;
    logic [7:0]      r_intensity;
    logic [1:0]      r_idx;
    logic [TW-1:0]   r_tmo;

    logic            w_tmoHit;
    logic            w_snapEn;
    logic            w_capture;
    logic            w_publish;
    logic            w_bypassOut;
    logic            w_abort;
    logic            w_tmoClr;
    logic            w_idxInc;
    logic            w_ldNext;
    logic [7:0]      w_rounded;

    assign w_tmoHit  = (r_tmo == TW'(TIMEOUT - 1));
    assign w_rounded = 8'((mul_result + 16'h0080) >> 8);
    assign mul_a     = r_snap[r_idx];
    assign mul_b     = r_intensity;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // BYPASS spends two cycles so its outputs land on the same edge offset
    // as a registered snapshot-to-output copy would.
    always_comb begin
        w_next      = r_state;
        w_snapEn    = 1'b0;
        w_capture   = 1'b0;
        w_publish   = 1'b0;
        w_bypassOut = 1'b0;
        w_abort     = 1'b0;
        w_tmoClr    = 1'b0;
        w_idxInc    = 1'b0;
        w_ldNext    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_snapEn = 1'b1;
                    w_tmoClr = 1'b1;
                    if (intensity == 8'hFF) begin
                        w_next = S_BYPASS;
                    end else begin
                        w_next   = S_REQ;
                        w_ldNext = 1'b1;
                    end
                end
            end
            S_BYPASS: begin
                if (r_tmo != '0) begin
                    w_bypassOut = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_REQ: begin
                w_ldNext = 1'b1;
                if (mul_rdy) begin
                    w_capture = 1'b1;
                    w_ldNext  = 1'b0;
                    w_tmoClr  = 1'b1;
                    w_next    = S_REL;
                end else if (w_tmoHit) begin
                    w_ldNext = 1'b0;
                    w_abort  = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_REL: begin
                if (!mul_rdy && (r_tmo != '0)) begin
                    w_tmoClr = 1'b1;
                    if (r_idx == 2'd3) begin
                        w_publish = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_idxInc = 1'b1;
                        w_ldNext = 1'b1;
                        w_next   = S_REQ;
                    end
                end else if (w_tmoHit) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap      <= '0;
            r_shadow    <= '0;
            r_intensity <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            mul_ld      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            w_out       <= '0;
        end else begin
            if (w_tmoClr) begin
                r_tmo <= '0;
            end else if (r_state != S_IDLE) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_snapEn) begin
                r_snap      <= {w_in, b_in, g_in, r_in};
                r_intensity <= intensity;
                r_idx       <= '0;
            end else if (w_idxInc) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_capture) begin
                r_shadow[r_idx] <= w_rounded;
            end

            mul_ld <= w_ldNext;
            done   <= w_publish | w_bypassOut;

            if (w_snapEn) begin
                err <= 1'b0;
            end else if (w_abort) begin
                err <= 1'b1;
            end

            // All four channels change on one edge so the PWM side never sees a mix.
            if (w_publish) begin
                {w_out, b_out, g_out, r_out} <= r_shadow;
            end else if (w_bypassOut) begin
                {w_out, b_out, g_out, r_out} <= r_snap;
            end
        end
    end
endmodule

// File: tb/tb_rgbw_scaler.sv
// tb_rgbw_scaler: randomized passes of rgbw_scaler against an arithmetic
// reference, with a behavioural model of the team multiplier.
module tb_rgbw_scaler;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  intensity = '0;
    logic [7:0]  rIn = '0, gIn = '0, bIn = '0, wIn = '0;
    logic [7:0]  r_out, g_out, b_out, w_out;
    logic        busy, done, err;
    logic        mul_ld;
    logic [7:0]  mul_a, mul_b;
    logic        mul_rdy;
    logic [15:0] mul_result;

    int nCompared = 0;
    int nMismatch = 0;
    int doneCount = 0;
    int ldRises = 0;
    int mulMode = 0;
    int holdExtra = 0;
    logic [31:0] lastOut = '0;

    rgbw_scaler #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(rstN), .start(start), .intensity(intensity),
        .r_in(rIn), .g_in(gIn), .b_in(bIn), .w_in(wIn),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .w_out(w_out),
        .busy(busy), .done(done), .err(err),
        .mul_ld(mul_ld), .mul_a(mul_a), .mul_b(mul_b),
        .mul_rdy(mul_rdy), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] refScale(input logic [7:0] v, input logic [7:0] k);
        int p;
        if (k == 8'hFF) return v;
        p = (int'(v) * int'(k) + 128) / 256;
        return 8'(p);
    endfunction

    // Multiplier: two-stage ld synchroniser, registered result; mulMode 2 never answers.
    logic mulS1, mulS2;
    int   mulHold;
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mulS1 <= 1'b0; mulS2 <= 1'b0; mul_rdy <= 1'b0; mul_result <= '0; mulHold <= 0;
        end else begin
            mulS1 <= mul_ld;
            mulS2 <= mulS1;
            if (mulMode == 2) begin
                mul_rdy <= 1'b0;
            end else if (mul_ld && mulS2) begin
                mul_rdy    <= 1'b1;
                mul_result <= 16'(mul_a) * 16'(mul_b);
                mulHold    <= holdExtra;
            end else if (mul_rdy && mulHold > 0) begin
                mulHold <= mulHold - 1;
            end else begin
                mul_rdy <= 1'b0;
            end
        end
    end

    // Handshake watcher: operand stability, low gap and no re-request over a live mul_rdy.
    logic prevLd = 1'b0, prevRdy = 1'b0;
    logic [7:0] prevA = '0, prevB = '0;
    int ldGap = 99;
    always @(negedge clk) begin
        if (done) doneCount++;
        if (mul_ld && prevLd) begin
            checkOutput("aStable", mul_a, prevA);
            checkOutput("bStable", mul_b, prevB);
        end
        if (mul_ld && !prevLd) begin
            ldRises++;
            checkOutput("ldGap", ldGap >= 2, 1);
            checkOutput("ldWhileRdy", prevRdy, 0);
        end
        ldGap   = mul_ld ? 0 : (ldGap < 99 ? ldGap + 1 : ldGap);
        prevLd  = mul_ld;
        prevRdy = mul_rdy;
        prevA   = mul_a;
        prevB   = mul_b;
    end

    task automatic scramble();
        rIn = 8'($urandom); gIn = 8'($urandom); bIn = 8'($urandom); wIn = 8'($urandom);
        intensity = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [7:0] r, g, b, w, k, input bit poke, input int tail);
        int expLat, lat, busyCnt, d0, l0;
        logic [31:0] expOut;
        expLat = (k == 8'hFF) ? 2 : 4 * (6 + holdExtra);
        expOut = {refScale(w, k), refScale(b, k), refScale(g, k), refScale(r, k)};
        d0 = doneCount;
        l0 = ldRises;
        rIn = r; gIn = g; bIn = b; wIn = w; intensity = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busyAtStart", busy, 1);
        checkOutput("ldAtStart", mul_ld, k != 8'hFF);
        checkOutput("errCleared", err, 0);
        busyCnt = 1;
        lat = 0;
        for (int n = 1; n <= 80 && lat == 0; n++) begin
            start = poke && (n == 3 || n == 10);
            if (n == 2 || start) scramble();
            @(posedge clk); #1;
            if (done) lat = n;
            else if (busy) busyCnt++;
        end
        start = 1'b0;
        checkOutput("doneLatency", lat, expLat);
        checkOutput("busyCycles", busyCnt, expLat);
        checkOutput("busyLow", busy, 0);
        checkOutput("outputs", {w_out, b_out, g_out, r_out}, expOut);
        lastOut = expOut;
        @(negedge clk);
        repeat (tail) @(negedge clk);
        #1;
        checkOutput("donePulses", doneCount - d0, 1);
        checkOutput("ldRequests", ldRises - l0, (k == 8'hFF) ? 0 : 4);
    endtask

    initial begin
        logic [7:0] k;
        int d0;
        #1;
        checkOutput("rstOutputs", {w_out, b_out, g_out, r_out}, 0);
        checkOutput("rstFlags", {busy, done, err, mul_ld}, 0);
        #21 rstN = 1'b1;
        @(negedge clk);

        applyStimulus(8'd255, 8'd128, 8'd1, 8'd0, 8'h80, 1'b0, 2);
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 2);
        applyStimulus(8'h12, 8'h34, 8'hAB, 8'hFE, 8'hFF, 1'b0, 2);
        applyStimulus(8'd255, 8'd255, 8'd255, 8'd255, 8'hFE, 1'b0, 0);
        applyStimulus(8'd200, 8'd100, 8'd50, 8'd25, 8'h3C, 1'b0, 2);
        applyStimulus(8'd90, 8'd180, 8'd45, 8'd135, 8'hA5, 1'b1, 2);

        holdExtra = 5;
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h77, 1'b0, 2);
        holdExtra = 0;

        for (int i = 0; i < 8; i++) begin
            k = (i % 4 == 3) ? 8'hFF : 8'($urandom);
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), k, 1'b0, i % 2);
        end

        mulMode = 2;
        d0 = doneCount;
        rIn = 8'h11; gIn = 8'h22; bIn = 8'h33; wIn = 8'h44; intensity = 8'h40; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("tmoBusyAt15", busy, 1);
        @(posedge clk); #1;
        checkOutput("tmoBusyAt16", busy, 0);
        checkOutput("tmoErr", err, 1);
        checkOutput("tmoLd", mul_ld, 0);
        checkOutput("tmoKeepOut", {w_out, b_out, g_out, r_out}, lastOut);
        @(negedge clk); #1;
        checkOutput("tmoNoDone", doneCount - d0, 0);
        mulMode = 0;
        repeat (3) @(negedge clk);
        applyStimulus(8'd255, 8'd128, 8'd1, 8'd0, 8'h80, 1'b0, 2);

        rIn = 8'h80; gIn = 8'h90; bIn = 8'hA0; wIn = 8'hB0; intensity = 8'h60; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("midPassLdG", mul_ld, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("asyncRstOut", {w_out, b_out, g_out, r_out}, 0);
        checkOutput("asyncRstLd", mul_ld, 0);
        checkOutput("asyncRstBusy", busy, 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'hC3, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
